// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the fabric-side UART receiver.
//   uart_rx_state_e : receiver FSM states
//   OVERSAMPLE      : ticks per bit period
//   MID_SAMPLE      : tick index (1-based) of the start-bit mid-point sample
//   DATA_BITS       : data bits per frame
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;
    localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider that pulses o_tick for one cycle every BAUD_DIV clocks.
// A synchronous clear restarts the count so tick phase can be aligned to an
// external event (e.g. a detected start edge).
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_clr   : synchronous clear of the divider count
//   o_tick  : one-cycle pulse at the count wrap
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned BAUD_DIV = 27
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == CNT_MAX)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/uart_rx_fabric.sv
// -----------------------------------------------------------------------------
// uart_rx_fabric
// Fabric-side UART receiver (8N1 / 8E1 / 8O1) with 16x oversampling. Received
// bytes are presented on a valid/ready interface; framing, parity and overrun
// conditions raise sticky flags.
// Ports:
//   CLK        : fabric clock
//   RESET_N    : asynchronous active-low reset
//   RX         : asynchronous serial input, idles high
//   RX_DATA    : received byte, LSB = first data bit on the line
//   RX_VALID   : RX_DATA holds an unconsumed byte
//   RX_READY   : consumer accepts the byte
//   FRAME_ERR  : sticky, stop bit sampled low
//   PARITY_ERR : sticky, parity mismatch
//   OVERRUN    : sticky, completed byte dropped because RX_DATA was still full
//   ERR_CLR    : one-cycle pulse clearing all sticky flags
//   BUSY       : receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_fabric
    import uart_rx_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 27,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       RX,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       FRAME_ERR,
    output logic       PARITY_ERR,
    output logic       OVERRUN,
    input  logic       ERR_CLR,
    output logic       BUSY
);

    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);

    logic           r_rx_meta;
    logic           r_rx_s;
    uart_rx_state_e r_state;
    logic [3:0]     r_sample_cnt;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_par_err;
    logic [7:0]     r_rx_data;
    logic           r_rx_valid;
    logic           r_frame_err;
    logic           r_parity_err;
    logic           r_overrun;

    logic           w_tick;
    logic           w_tick_clr;
    logic           w_mid_tick;
    logic           w_bit_tick;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Realign the divider on the detected start edge so mid-bit sampling holds.
    assign w_tick_clr = (r_state == IDLE) && !r_rx_s;

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_clr   (w_tick_clr),
        .o_tick  (w_tick)
    );

    assign w_mid_tick = w_tick && (r_sample_cnt == MID_LAST);
    assign w_bit_tick = w_tick && (r_sample_cnt == BIT_LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= IDLE;
            r_sample_cnt <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_par_err    <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // Clear first so a same-cycle set below takes priority.
            if (ERR_CLR) begin
                r_frame_err  <= 1'b0;
                r_parity_err <= 1'b0;
                r_overrun    <= 1'b0;
            end

            if (r_rx_valid && RX_READY) begin
                r_rx_valid <= 1'b0;
            end

            if (w_tick && (r_state != IDLE) && (r_state != BREAK)) begin
                r_sample_cnt <= r_sample_cnt + 4'd1;
            end

            unique case (r_state)
                IDLE: begin
                    if (!r_rx_s) begin
                        r_state      <= START;
                        r_sample_cnt <= 4'd0;
                        r_par_err    <= 1'b0;
                    end
                end
                START: begin
                    if (w_mid_tick) begin
                        if (r_rx_s) begin
                            r_state <= IDLE;  // glitch shorter than half a bit
                        end else begin
                            r_state      <= DATA;
                            r_sample_cnt <= 4'd0;
                            r_bit_cnt    <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        // LSB arrives first, so shift in at the MSB end.
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == DATA_LAST) begin
                            r_state <= PAR_EN ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_tick) begin
                        r_par_err <= (r_rx_s != ((^r_shift) ^ PAR_ODD));
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_bit_tick) begin
                        if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end else if (r_par_err) begin
                            r_parity_err <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            if (!r_rx_valid || RX_READY) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            r_state <= IDLE;
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a held-low
                    // line cannot retrigger a frame.
                    if (r_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign RX_DATA    = r_rx_data;
    assign RX_VALID   = r_rx_valid;
    assign FRAME_ERR  = r_frame_err;
    assign PARITY_ERR = r_parity_err;
    assign OVERRUN    = r_overrun;
    assign BUSY       = (r_state != IDLE);

endmodule
